trig_cordic: RTL and testbench

- Iterative CORDIC sine/cosine unit sitting directly downstream of the frame-rate angle generator.
- Consumes the 12-bit unsigned Q4.8 rotation angle `theta` (radians) once per frame and produces signed Q4.8 sin/cos.
- Those values feed the rotation-matrix / vertex-transform stage of the 3D renderer.
- Multi-cycle, start/done handshake; one result in flight at a time.

---
 rtl/trig_cordic.sv | 177 +++++++++++++++++
 tb/tb_trig_cordic.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_cordic.sv
// Iterative CORDIC sin/cos for Q4.8 angles with a start/done handshake.
// Optional TRIG_CORDIC_ROUND_EN: round-half-up output conversion.
module trig_cordic #(
  parameter int ITER = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [11:0] theta,
  output logic        busy,
  output logic        done,
  output logic [11:0] sin_out,
  output logic [11:0] cos_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_ROTATE = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  localparam logic [11:0] TWO_PI  = 12'h648;
  localparam logic [11:0] PI      = 12'h324;
  localparam logic [11:0] HALF_PI = 12'h192;
  localparam logic [11:0] TH_PI2  = 12'h4B6;

  localparam logic signed [17:0] K_INIT = 18'sd9949;
  localparam logic [3:0] LAST = 4'(ITER - 1);

  logic [1:0]         state;
  logic [11:0]        a;
  logic [3:0]         i;
  logic               neg;
  logic signed [17:0] x;
  logic signed [17:0] y;
  logic signed [17:0] z;

  function automatic logic signed [17:0] atan_rom(
    input logic [3:0] idx
  );
    logic signed [17:0] v;
    case (idx)
      4'd0:    v = 18'sd12868;
      4'd1:    v = 18'sd7596;
      4'd2:    v = 18'sd4014;
      4'd3:    v = 18'sd2037;
      4'd4:    v = 18'sd1023;
      4'd5:    v = 18'sd512;
      4'd6:    v = 18'sd256;
      4'd7:    v = 18'sd128;
      4'd8:    v = 18'sd64;
      4'd9:    v = 18'sd32;
      4'd10:   v = 18'sd16;
      4'd11:   v = 18'sd8;
      4'd12:   v = 18'sd4;
      4'd13:   v = 18'sd2;
      default: v = 18'sd0;
    endcase
    return v;
  endfunction

  // Fold [0, 2pi) into [-pi/2, pi/2]; neg marks a half-turn.
  logic signed [12:0] a_s;
  logic signed [12:0] zf;
  logic               negf;
  logic signed [17:0] z_init;

  always_comb begin
    a_s  = signed'({1'b0, a});
    zf   = a_s;
    negf = 1'b0;
    if (a <= HALF_PI) begin
      zf   = a_s;
      negf = 1'b0;
    end else if (a < TH_PI2) begin
      zf   = a_s - signed'({1'b0, PI});
      negf = 1'b1;
    end else begin
      zf   = a_s - signed'({1'b0, TWO_PI});
      negf = 1'b0;
    end
    z_init = signed'({{5{zf[12]}}, zf}) <<< 6;
  end

  logic signed [17:0] xs;
  logic signed [17:0] ys;
  logic signed [17:0] at;
  logic signed [17:0] x_n;
  logic signed [17:0] y_n;
  logic signed [17:0] z_n;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = atan_rom(i);
    if (!z[17]) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - at;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + at;
    end
  end

  logic signed [17:0] xo;
  logic signed [17:0] yo;
  logic signed [17:0] xr;
  logic signed [17:0] yr;

  always_comb begin
    xo = neg ? -x : x;
    yo = neg ? -y : y;
`ifdef TRIG_CORDIC_ROUND_EN
    xr = xo + 18'sd32;
    yr = yo + 18'sd32;
`else
    xr = xo;
    yr = yo;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sin_out <= 12'h000;
      cos_out <= 12'h100;
      a       <= 12'h000;
      i       <= 4'd0;
      neg     <= 1'b0;
      x       <= 18'sd0;
      y       <= 18'sd0;
      z       <= 18'sd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a     <= theta;
            busy  <= 1'b1;
            state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (a >= TWO_PI) begin
            a <= a - TWO_PI;
          end else begin
            z     <= z_init;
            neg   <= negf;
            x     <= K_INIT;
            y     <= 18'sd0;
            i     <= 4'd0;
            state <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          i <= i + 4'd1;
          if (i == LAST) state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          cos_out <= xr[17:6];
          sin_out <= yr[17:6];
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_cordic.sv
// Directed self-checking bench for trig_cordic.
// Expected sin/cos are hand-computed from the real angle values.
module tb_trig_cordic;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [11:0] theta;
  logic        busy;
  logic        done;
  logic [11:0] sin_out;
  logic [11:0] cos_out;

  int checks = 0;
  int errors = 0;
  logic busy_seen;

`ifdef TRIG_CORDIC_ROUND_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 3;
`endif

  trig_cordic #(.ITER(12)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .theta(theta),
    .busy(busy),
    .done(done),
    .sin_out(sin_out),
    .cos_out(cos_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int sdiff(input logic [11:0] v, input int ref_v);
    int d;
    d = int'($signed(v)) - ref_v;
    return (d < 0) ? -d : d;
  endfunction

  // Pulse start, then count edges until done (bounded to 40 cycles).
  task automatic run_op(
    input  logic [11:0] th,
    output int          lat,
    output logic [11:0] s,
    output logic [11:0] c
  );
    @(posedge Clk); #1;
    start = 1'b1;
    theta = th;
    @(posedge Clk); #1;
    start = 1'b0;
    theta = 12'h000;
    busy_seen = busy;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    s = sin_out;
    c = cos_out;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    start = 1'b0;
    theta = 12'h000;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (sin_out !== 12'h000 || cos_out !== 12'h100) begin
      errors++;
      $display("FAIL reset_out sin=%h cos=%h want 000 100",
               sin_out, cos_out);
    end
  endtask

  task automatic test_angles;
    logic [11:0] th [8] = '{12'h000, 12'h192, 12'h324, 12'h4B6,
                            12'h648, 12'hFFF, 12'h100, 12'h200};
    int es [8] = '{0, 256, 0, -256, 0, -74, 215, 233};
    int ec [8] = '{256, 0, -256, 0, 256, -245, 138, -107};
    int el [8] = '{14, 14, 14, 14, 15, 16, 14, 14};
    int lat;
    logic [11:0] s, c;
    for (int k = 0; k < 8; k++) begin
      run_op(th[k], lat, s, c);
      checks++;
      if (lat !== el[k]) begin
        errors++;
        $display("FAIL latency th=%h got %0d want %0d", th[k], lat, el[k]);
      end
      checks++;
      if (sdiff(s, es[k]) > TOL) begin
        errors++;
        $display("FAIL sin th=%h got %0d want %0d", th[k],
                 $signed(s), es[k]);
      end
      checks++;
      if (sdiff(c, ec[k]) > TOL) begin
        errors++;
        $display("FAIL cos th=%h got %0d want %0d", th[k],
                 $signed(c), ec[k]);
      end
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b want 1", busy_seen);
    end
    @(posedge Clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    int lat = -1;
    logic [11:0] s = 12'h000;
    logic [11:0] c = 12'h000;
    @(posedge Clk); #1;
    start = 1'b1;
    theta = 12'h100;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin
        start = 1'b1;
        theta = 12'h324;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          s = sin_out;
          c = cos_out;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || lat !== 14) begin
      errors++;
      $display("FAIL busy_ignore dones=%0d lat=%0d want 1 14", ndone, lat);
    end
    checks++;
    if (sdiff(s, 215) > TOL || sdiff(c, 138) > TOL) begin
      errors++;
      $display("FAIL busy_ignore_val sin=%0d cos=%0d want 215 138",
               $signed(s), $signed(c));
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [11:0] s, c;
    run_op(12'h000, lat, s, c);
    start = 1'b1;
    theta = 12'h192;
    @(posedge Clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL b2b_latency got %0d want 14", lat);
    end
    checks++;
    if (sdiff(sin_out, 256) > TOL || sdiff(cos_out, 0) > TOL) begin
      errors++;
      $display("FAIL b2b_val sin=%0d cos=%0d want 256 0",
               $signed(sin_out), $signed(cos_out));
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    int lat;
    logic [11:0] s, c;
    @(posedge Clk); #1;
    start = 1'b1;
    theta = 12'h200;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        sin_out !== 12'h000 || cos_out !== 12'h100) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b sin=%h cos=%h want 0 0 000 100",
               busy, done, sin_out, cos_out);
    end
    for (int n = 0; n < 25; n++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_reset_nodone got %0d want 0", ndone);
    end
    run_op(12'h100, lat, s, c);
    checks++;
    if (lat !== 14 || sdiff(s, 215) > TOL || sdiff(c, 138) > TOL) begin
      errors++;
      $display("FAIL after_reset lat=%0d sin=%0d cos=%0d want 14 215 138",
               lat, $signed(s), $signed(c));
    end
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    theta = 12'h000;
    busy_seen = 1'b0;
    test_reset();
    test_angles();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
